// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV64I decode stage with register file, write-back bypass and load-use stall
//
// Purpose: decodes one 32-bit instruction per handshake into an operand/control
// bundle for execute, owns the 32 x XLEN architectural register file and
// inserts a bubble when the incoming instruction reads the destination of a
// load still sitting in the output slot.
//
// Optional feature: define DECODE_RV64W_EN to decode OP-32 / OP-IMM-32 and
// expose the word_op output; without it those opcodes are flagged illegal.
//
// Ports:
//   CLK, reset                clock, asynchronous active-low reset
//   in_valid/in_ready/inst    fetch-side handshake and instruction word
//   wb_en/wb_rd/wb_value      register write-back port (bypassed into reads)
//   out_valid/out_ready       execute-side handshake
//   rd, rs1, rs2              register indices actually used by the slot
//   funct3, funct7            instruction function fields
//   imm                       sign-extended immediate
//   op1, op2, store_data      operands (op2 is imm for immediate forms)
//   write_back, imm_flag, mem_acc, load_flag, store_flag, illegal  control flags
//   word_op                   32-bit word operation (DECODE_RV64W_EN only)
//   bubble_cnt                saturating count of load-use bubbles
module decode_stage #(
    parameter int          XLEN     = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] store_data,
    output logic            write_back,
    output logic            imm_flag,
    output logic            mem_acc,
    output logic            load_flag,
    output logic            store_flag,
    output logic            illegal,
`ifdef DECODE_RV64W_EN
    output logic            word_op,
`endif
    output logic [15:0]     bubble_cnt
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
`ifdef DECODE_RV64W_EN
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
`endif

    typedef struct packed {
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] store_data;
        logic            write_back;
        logic            imm_flag;
        logic            mem_acc;
        logic            load_flag;
        logic            store_flag;
        logic            illegal;
`ifdef DECODE_RV64W_EN
        logic            word_op;
`endif
    } bundle_t;

    logic [XLEN-1:0] regs [32];
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic            is_op;
    logic            is_opimm;
    logic            is_load;
    logic            is_store;
    logic            is_lui;
    logic            reads_rs1;
    logic            reads_rs2;
    logic            hazard;
    logic            load_en;
    bundle_t         cur;
    bundle_t         dec;
    bundle_t         bubble;

    assign src1 = inst[19:15];
    assign src2 = inst[24:20];

    // Same-cycle write-back wins over the stored value; x0 is hardwired zero.
    assign src1_val = (src1 == 5'd0) ? '0 :
                      (wb_en && wb_rd == src1) ? wb_value : regs[src1];
    assign src2_val = (src2 == 5'd0) ? '0 :
                      (wb_en && wb_rd == src2) ? wb_value : regs[src2];

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};

`ifdef DECODE_RV64W_EN
    assign is_op    = (inst[6:0] == OPC_OP)    || (inst[6:0] == OPC_OP32);
    assign is_opimm = (inst[6:0] == OPC_OPIMM) || (inst[6:0] == OPC_OPIMM32);
`else
    assign is_op    = (inst[6:0] == OPC_OP);
    assign is_opimm = (inst[6:0] == OPC_OPIMM);
`endif
    assign is_load  = (inst[6:0] == OPC_LOAD);
    assign is_store = (inst[6:0] == OPC_STORE);
    assign is_lui   = (inst[6:0] == OPC_LUI);

    // Bubble slot: fields of NOP_INST, but no flags set and no destination.
    always_comb begin
        bubble        = '0;
        bubble.rs1    = NOP_INST[19:15];
        bubble.funct3 = NOP_INST[14:12];
        bubble.funct7 = NOP_INST[31:25];
        bubble.imm    = {{(XLEN-12){NOP_INST[31]}}, NOP_INST[31:20]};
        bubble.op2    = bubble.imm;
    end

    // rs1/rs2 outputs report only the indices the instruction really reads.
    always_comb begin
        dec       = '0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        if (is_op) begin
            dec.rd         = inst[11:7];
            dec.rs1        = src1;
            dec.rs2        = src2;
            dec.funct3     = inst[14:12];
            dec.funct7     = inst[31:25];
            dec.op1        = src1_val;
            dec.op2        = src2_val;
            dec.write_back = 1'b1;
            reads_rs1      = 1'b1;
            reads_rs2      = 1'b1;
        end else if (is_opimm || is_load) begin
            dec.rd         = inst[11:7];
            dec.rs1        = src1;
            dec.funct3     = inst[14:12];
            dec.funct7     = inst[31:25];
            dec.imm        = imm_i;
            dec.op1        = src1_val;
            dec.op2        = imm_i;
            dec.imm_flag   = 1'b1;
            dec.write_back = 1'b1;
            dec.mem_acc    = is_load;
            dec.load_flag  = is_load;
            reads_rs1      = 1'b1;
        end else if (is_store) begin
            dec.rs1        = src1;
            dec.rs2        = src2;
            dec.funct3     = inst[14:12];
            dec.imm        = imm_s;
            dec.op1        = src1_val;
            dec.op2        = imm_s;
            dec.store_data = src2_val;
            dec.imm_flag   = 1'b1;
            dec.mem_acc    = 1'b1;
            dec.store_flag = 1'b1;
            reads_rs1      = 1'b1;
            reads_rs2      = 1'b1;
        end else if (is_lui) begin
            dec.rd         = inst[11:7];
            dec.imm        = imm_u;
            dec.op2        = imm_u;
            dec.imm_flag   = 1'b1;
            dec.write_back = 1'b1;
        end else begin
            dec         = bubble;
            dec.illegal = 1'b1;
        end
`ifdef DECODE_RV64W_EN
        dec.word_op = (inst[6:0] == OPC_OP32) || (inst[6:0] == OPC_OPIMM32);
`endif
    end

    assign load_en = !out_valid || out_ready;
    assign hazard  = out_valid && cur.load_flag && (cur.rd != 5'd0) && in_valid &&
                     ((reads_rs1 && src1 == cur.rd) || (reads_rs2 && src2 == cur.rd));
    assign in_ready = reset && load_en && !hazard;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cur        <= '0;
            out_valid  <= 1'b0;
            bubble_cnt <= 16'd0;
        end else if (load_en) begin
            if (in_valid && hazard) begin
                cur       <= bubble;
                out_valid <= 1'b1;
                if (bubble_cnt != 16'hFFFF) begin
                    bubble_cnt <= bubble_cnt + 16'd1;
                end
            end else if (in_valid) begin
                cur       <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_value;
        end
    end

    assign rd         = cur.rd;
    assign rs1        = cur.rs1;
    assign rs2        = cur.rs2;
    assign funct3     = cur.funct3;
    assign funct7     = cur.funct7;
    assign imm        = cur.imm;
    assign op1        = cur.op1;
    assign op2        = cur.op2;
    assign store_data = cur.store_data;
    assign write_back = cur.write_back;
    assign imm_flag   = cur.imm_flag;
    assign mem_acc    = cur.mem_acc;
    assign load_flag  = cur.load_flag;
    assign store_flag = cur.store_flag;
    assign illegal    = cur.illegal;
`ifdef DECODE_RV64W_EN
    assign word_op    = cur.word_op;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm, op1, op2, store_data;
    logic        write_back, imm_flag, mem_acc, load_flag, store_flag, illegal;
    logic [15:0] bubble_cnt;
`ifdef DECODE_RV64W_EN
    logic        word_op;
`endif

    decode_stage dut (
        .CLK(CLK), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .op1(op1), .op2(op2), .store_data(store_data),
        .write_back(write_back), .imm_flag(imm_flag), .mem_acc(mem_acc),
        .load_flag(load_flag), .store_flag(store_flag), .illegal(illegal),
`ifdef DECODE_RV64W_EN
        .word_op(word_op),
`endif
        .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] I_ADD35  = 32'h005281B3; // ADD  x3,x5,x5
    localparam logic [31:0] I_LD     = 32'h0082B303; // LD   x6,8(x5)
    localparam logic [31:0] I_ADD765 = 32'h005303B3; // ADD  x7,x6,x5
    localparam logic [31:0] I_SD     = 32'hFE62BE23; // SD   x6,-4(x5)
    localparam logic [31:0] I_ADDI19 = 32'h00148093; // ADDI x1,x9,1
    localparam logic [31:0] I_ADD0   = 32'h00000533; // ADD  x10,x0,x0
    localparam logic [31:0] I_LUI    = 32'h80000137; // LUI  x2,0x80000
    localparam logic [31:0] I_ILL    = 32'h0000007F;
    localparam logic [31:0] I_ADDI85 = 32'h00028413; // ADDI x8,x5,0

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm, op1, op2, sd;
        logic        wb, immf, mem, ld, st, ill, wop;
    } exp_t;

    logic [63:0] m_regs [32];
    logic        m_valid;
    logic [15:0] m_cnt;
    exp_t        m_b;

    function automatic logic [63:0] rreg(input logic [4:0] i);
        if (i == 0) return 64'd0;
        if (wb_en && wb_rd == i) return wb_value;
        return m_regs[i];
    endfunction

    function automatic exp_t mdecode(input logic [31:0] w);
        exp_t e = '0;
        logic [6:0] opc = w[6:0];
        logic isop = (opc == 7'h33);
        logic isimm = (opc == 7'h13) || (opc == 7'h03);
`ifdef DECODE_RV64W_EN
        e.wop = (opc == 7'h3B) || (opc == 7'h1B);
        isop  = isop || (opc == 7'h3B);
        isimm = isimm || (opc == 7'h1B);
`endif
        if (isop) begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
            e.f3 = w[14:12]; e.f7 = w[31:25];
            e.op1 = rreg(w[19:15]); e.op2 = rreg(w[24:20]); e.wb = 1;
        end else if (isimm) begin
            e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12]; e.f7 = w[31:25];
            e.imm = longint'($signed(w[31:20]));
            e.op1 = rreg(w[19:15]); e.op2 = e.imm; e.immf = 1; e.wb = 1;
            e.mem = (opc == 7'h03); e.ld = (opc == 7'h03);
        end else if (opc == 7'h23) begin
            e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12];
            e.imm = longint'($signed({w[31:25], w[11:7]}));
            e.op1 = rreg(w[19:15]); e.op2 = e.imm; e.sd = rreg(w[24:20]);
            e.immf = 1; e.mem = 1; e.st = 1;
        end else if (opc == 7'h37) begin
            e.rd = w[11:7];
            e.imm = longint'($signed({w[31:12], 12'h000}));
            e.op2 = e.imm; e.immf = 1; e.wb = 1;
        end else begin
            e = '0; e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [6:0] opc = w[6:0];
        logic r1 = (opc == 7'h33) || (opc == 7'h13) || (opc == 7'h03) || (opc == 7'h23);
        logic r2 = (opc == 7'h33) || (opc == 7'h23);
`ifdef DECODE_RV64W_EN
        r1 = r1 || (opc == 7'h3B) || (opc == 7'h1B);
        r2 = r2 || (opc == 7'h3B);
`endif
        return (r1 && w[19:15] == r) || (r2 && w[24:20] == r);
    endfunction

    function automatic logic m_hz();
        return m_valid && m_b.ld && m_b.rd != 0 && in_valid && reads_reg(inst, m_b.rd);
    endfunction

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_cnt   <= 16'd0;
            m_b     <= '0;
            for (int i = 0; i < 32; i++) m_regs[i] <= 64'd0;
        end else begin
            if (!m_valid || out_ready) begin
                if (in_valid && m_hz()) begin
                    m_b     <= '0;
                    m_valid <= 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                end else if (in_valid) begin
                    m_b     <= mdecode(inst);
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (wb_en && wb_rd != 0) m_regs[wb_rd] <= wb_value;
        end
    end

    // Compare process: every cycle, mid-way through the low phase.
    always @(negedge CLK) begin
        #2;
        chk("m_out_valid", out_valid, m_valid);
        chk("m_bubble_cnt", bubble_cnt, m_cnt);
        chk("m_in_ready", in_ready, reset && (!m_valid || out_ready) && !m_hz());
        if (reset && m_valid) begin
            chk("m_rd", rd, m_b.rd);
            chk("m_rs1", rs1, m_b.rs1);
            chk("m_rs2", rs2, m_b.rs2);
            chk("m_funct3", funct3, m_b.f3);
            chk("m_funct7", funct7, m_b.f7);
            chk("m_imm", imm, m_b.imm);
            chk("m_op1", op1, m_b.op1);
            chk("m_op2", op2, m_b.op2);
            chk("m_store_data", store_data, m_b.sd);
            chk("m_flags", {write_back, imm_flag, mem_acc, load_flag, store_flag, illegal},
                {m_b.wb, m_b.immf, m_b.mem, m_b.ld, m_b.st, m_b.ill});
`ifdef DECODE_RV64W_EN
            chk("m_word_op", word_op, m_b.wop);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] i, input logic we,
                         input logic [4:0] wr, input logic [63:0] wv, input logic ordy);
        @(negedge CLK);
        in_valid = v; inst = i; wb_en = we; wb_rd = wr; wb_value = wv; out_ready = ordy;
    endtask

    task automatic after_edge();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 0; inst = 0; wb_en = 0; wb_rd = 0; wb_value = 0; out_ready = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_op1", op1, 0);
        @(negedge CLK);
        reset = 1'b1;
        #1 chk("in_ready_after_reset", in_ready, 1);

        drive(0, 0, 1, 5, 64'h1234, 1);                 // x5 = 0x1234
        drive(1, I_ADD35, 0, 0, 0, 1);
        after_edge();
        chk("add_valid", out_valid, 1);
        chk("add_op1", op1, 64'h1234);
        chk("add_op2", op2, 64'h1234);
        chk("add_rd", rd, 3);
        chk("add_wb", write_back, 1);

        drive(1, I_LD, 0, 0, 0, 1);
        after_edge();
        chk("ld_load_flag", load_flag, 1);
        chk("ld_imm", imm, 64'd8);
        chk("ld_op1", op1, 64'h1234);
        chk("ld_funct3", funct3, 3'd3);

        drive(1, I_ADD765, 0, 0, 0, 1);
        #1 chk("hazard_in_ready", in_ready, 0);
        after_edge();
        chk("bubble_valid", out_valid, 1);
        chk("bubble_rd", rd, 0);
        chk("bubble_wb", write_back, 0);
        chk("bubble_cnt1", bubble_cnt, 1);

        drive(1, I_ADD765, 1, 6, 64'h55, 1);            // load data returns as ADD retries
        #1 chk("after_bubble_in_ready", in_ready, 1);
        after_edge();
        chk("add7_rd", rd, 7);
        chk("add7_op1", op1, 64'h55);
        chk("add7_op2", op2, 64'h1234);

        drive(1, I_SD, 0, 0, 0, 1);
        after_edge();
        chk("sd_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sd_store_flag", store_flag, 1);
        chk("sd_mem_acc", mem_acc, 1);
        chk("sd_wb", write_back, 0);
        chk("sd_store_data", store_data, 64'h55);
        chk("sd_rd", rd, 0);

        for (int k = 0; k < 3; k++) begin
            drive(1, I_ADDI19, 0, 0, 0, 0);
            #1 chk("stall_in_ready", in_ready, 0);
            after_edge();
            chk("stall_imm_held", imm, 64'hFFFF_FFFF_FFFF_FFFC);
            chk("stall_store_flag_held", store_flag, 1);
        end

        drive(1, I_ADDI19, 1, 9, 64'hABCD, 1);          // write-back x9 in the accept cycle
        #1 chk("release_in_ready", in_ready, 1);
        after_edge();
        chk("addi_op1_bypass", op1, 64'hABCD);
        chk("addi_op2", op2, 64'd1);
        chk("addi_rd", rd, 1);

        drive(1, I_ADD0, 1, 0, 64'hFFFF, 1);            // write to x0 must be dropped
        after_edge();
        chk("x0_bypass_op1", op1, 0);
        drive(1, I_ADD0, 0, 0, 0, 1);
        after_edge();
        chk("x0_still_zero", op1, 0);

        drive(1, I_LUI, 0, 0, 0, 1);
        after_edge();
        chk("lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_op1", op1, 0);
        chk("lui_rd", rd, 2);

        drive(1, I_ILL, 0, 0, 0, 1);
        after_edge();
        chk("ill_flag", illegal, 1);
        chk("ill_wb", write_back, 0);
        chk("ill_valid", out_valid, 1);
        chk("ill_no_count", bubble_cnt, 1);

        drive(0, 0, 0, 0, 0, 1);
        after_edge();
        chk("idle_valid", out_valid, 0);

        drive(1, I_LD, 0, 0, 0, 1);
        drive(1, I_ADDI85, 0, 0, 0, 1);                 // reads x5 only: no hazard
        #1 chk("no_hazard_in_ready", in_ready, 1);
        after_edge();
        chk("no_hazard_rd", rd, 8);
        chk("no_hazard_cnt", bubble_cnt, 1);

        drive(1, I_LD, 0, 0, 0, 1);
        drive(1, I_ADD765, 0, 0, 0, 0);                 // stalled behind LD with hazard
        after_edge();
        chk("midstall_in_ready", in_ready, 0);
        #2 reset = 1'b0;
        #1;
        chk("midstall_rst_valid", out_valid, 0);
        chk("midstall_rst_cnt", bubble_cnt, 0);
        @(negedge CLK);
        reset = 1'b1; in_valid = 0;
        drive(1, I_ADD35, 0, 0, 0, 1);
        after_edge();
        chk("regs_cleared_op1", op1, 0);

        repeat (2) @(negedge CLK);
        #3;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
